// File: rtl/useq_nextaddr.sv
// ============================================================================
// Module   : useq_nextaddr
// Brief    : Microsequencer next-address unit with a registered micro-PC and
//            a circular call/return stack. Define USEQ_STKCHK_EN to enable
//            the sticky stack overflow/underflow flags.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module useq_nextaddr #(
    parameter int            AW     = 12,
    parameter int            DEPTH  = 4,
    parameter logic [AW-1:0] RSTVEC = '0,
    parameter logic [AW-1:0] PFVEC  = {AW{1'b1}}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clken,
    input  logic                     pageFAIL,
    input  logic                     call,
    input  logic                     ret,
    input  logic [AW-1:0]            cromJ,
    input  logic [AW-1:0]            dispADDR,
    input  logic [AW-1:0]            skipADDR,
    output logic [AW-1:0]            addr,
    output logic [AW-1:0]            dispRET,
    output logic [AW-1:0]            uPC,
    output logic [$clog2(DEPTH):0]   stkCOUNT,
    output logic                     stkOVF,
    output logic                     stkUNF
);

    localparam int               c_spw  = $clog2(DEPTH);
    localparam logic [c_spw:0]   c_full = (c_spw+1)'(DEPTH);

    // Stack RAM has no reset so it can map onto distributed memory.
    logic [AW-1:0]    r_stack [DEPTH];
    logic [c_spw-1:0] r_sp;
    logic [c_spw:0]   r_count;
    logic [AW-1:0]    r_upc;

    logic [c_spw-1:0] w_top;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic             w_replace;
    logic             w_push_only;
    logic             w_pop_only;

    assign addr    = rst      ? RSTVEC :
                     pageFAIL ? PFVEC  : (dispADDR | skipADDR | cromJ);
    assign w_top   = r_sp - 1'b1;
    assign dispRET = r_stack[w_top];

    assign w_push      = clken & ~rst & (call | pageFAIL);
    assign w_pop       = clken & ~rst & ret & ~pageFAIL;
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_full);
    // A simultaneous call/return on an empty stack degenerates to a push.
    assign w_replace   = w_push & w_pop & ~w_empty;
    assign w_push_only = w_push & ~w_replace;
    assign w_pop_only  = w_pop & ~w_push;

    always_ff @(posedge clk) begin
        if (w_replace) begin
            r_stack[w_top] <= addr;
        end else if (w_push_only) begin
            r_stack[r_sp] <= addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_upc   <= RSTVEC;
            r_sp    <= '0;
            r_count <= '0;
        end else if (clken) begin
            r_upc <= addr;
            if (w_push_only) begin
                r_sp <= r_sp + 1'b1;
                if (!w_full) begin
                    r_count <= r_count + 1'b1;
                end
            end else if (w_pop_only) begin
                r_sp <= r_sp - 1'b1;
                if (!w_empty) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

    assign uPC      = r_upc;
    assign stkCOUNT = r_count;

`ifdef USEQ_STKCHK_EN
    logic r_ovf;
    logic r_unf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_push_only && w_full) begin
                r_ovf <= 1'b1;
            end
            if (w_pop_only && w_empty) begin
                r_unf <= 1'b1;
            end
        end
    end

    assign stkOVF = r_ovf;
    assign stkUNF = r_unf;
`else
    assign stkOVF = 1'b0;
    assign stkUNF = 1'b0;
`endif

endmodule

`default_nettype wire
